// File: rtl/fractal_sync_1d_rf_issue_if.sv
// Upstream request and downstream completed-barrier handshakes of one RF issue port.
// The master drives requests and accepts responses; the slave is the issue stage.
interface fractal_sync_1d_rf_issue_if #(
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned SD_WIDTH    = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [LEVEL_WIDTH-1:0] req_level;
    logic [ID_WIDTH-1:0]    req_id;
    logic [SD_WIDTH-1:0]    req_sd;
    logic                   req_local;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [LEVEL_WIDTH-1:0] rsp_level;
    logic [ID_WIDTH-1:0]    rsp_id;
    logic [SD_WIDTH-1:0]    rsp_sd;
    logic                   rsp_local;

    modport master (
        output req_valid, req_level, req_id, req_sd, req_local,
        input  req_ready,
        input  rsp_valid, rsp_level, rsp_id, rsp_sd, rsp_local,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_level, req_id, req_sd, req_local,
        output req_ready,
        output rsp_valid, rsp_level, rsp_id, rsp_sd, rsp_local,
        input  rsp_ready
    );
endinterface

// File: rtl/fractal_sync_1d_rf_issue.sv
// Issue stage for one port of the 1D sync register file: buffers requests in a FIFO,
// checks the head against the RF and drops, errors, re-queues or responds on the verdict.
package fractal_sync_pkg;
    localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_1d_rf_issue #(
    parameter  int unsigned LEVEL_WIDTH = 1,
    parameter  int unsigned ID_WIDTH    = 1,
    parameter  int unsigned FIFO_DEPTH  = 4,
    parameter  int unsigned MAX_BYPASS  = 7,
    localparam int unsigned SD_WIDTH    = fractal_sync_pkg::SD_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fractal_sync_1d_rf_issue_if.slave bus,
    output logic [LEVEL_WIDTH-1:0] level_o,
    output logic [ID_WIDTH-1:0]    id_o,
    output logic [SD_WIDTH-1:0]    sd_local_o,
    output logic                   check_local_o,
    output logic                   check_remote_o,
    input  logic                   present_local_i,
    input  logic                   present_remote_i,
    input  logic                   id_err_i,
    input  logic                   sig_err_i,
    input  logic                   bypass_local_i,
    input  logic                   bypass_remote_i,
    input  logic                   ignore_local_i,
    input  logic                   ignore_remote_i,
    input  logic [SD_WIDTH-1:0]    sd_local_i,
    output logic                   err_o,
    output logic [ID_WIDTH-1:0]    err_id_o
);
    localparam int unsigned CNT_W = $clog2(MAX_BYPASS + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [LEVEL_WIDTH-1:0] level;
        logic [ID_WIDTH-1:0]    id;
        logic [SD_WIDTH-1:0]    sd;
        logic                   is_local;
        logic [CNT_W-1:0]       bypass_cnt;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CHECK, EVAL, RESP} state_e;

    entry_t                 mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, push_idx;
    logic [OCC_W-1:0]       cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   rsp_valid_q, rsp_valid_d, rsp_local_q, rsp_local_d;
    logic [LEVEL_WIDTH-1:0] rsp_level_q, rsp_level_d;
    logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d, err_id_q, err_id_d;
    logic [SD_WIDTH-1:0]    rsp_sd_q, rsp_sd_d;
    logic                   err_q, err_d;

    logic   empty, full, push, pop, repush;
    logic   v_ignore, v_err, v_bypass, v_present;
    entry_t head, new_entry, repush_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == OCC_W'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];

    assign bus.req_ready = !full && !rst_i;
    assign push          = bus.req_valid && bus.req_ready;

    assign level_o        = empty ? '0 : head.level;
    assign id_o           = empty ? '0 : head.id;
    assign sd_local_o     = empty ? '0 : head.sd;
    assign check_local_o  = (state_q == CHECK) && head.is_local;
    assign check_remote_o = (state_q == CHECK) && !head.is_local;

    // Only the verdict of the side that was actually checked is considered.
    assign v_ignore  = head.is_local ? ignore_local_i  : ignore_remote_i;
    assign v_err     = head.is_local ? id_err_i        : sig_err_i;
    assign v_bypass  = head.is_local ? bypass_local_i  : bypass_remote_i;
    assign v_present = head.is_local ? present_local_i : present_remote_i;

    always_comb begin
        new_entry            = '0;
        new_entry.level      = bus.req_level;
        new_entry.id         = bus.req_id;
        new_entry.sd         = bus.req_sd;
        new_entry.is_local   = bus.req_local;
        repush_entry            = head;
        repush_entry.bypass_cnt = head.bypass_cnt + CNT_W'(1);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        pop         = 1'b0;
        repush      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_level_d = rsp_level_q;
        rsp_id_d    = rsp_id_q;
        rsp_sd_d    = rsp_sd_q;
        rsp_local_d = rsp_local_q;
        err_d       = 1'b0;
        err_id_d    = '0;
        unique case (state_q)
            IDLE:  if (!empty) state_d = CHECK;
            CHECK: state_d = EVAL;
            EVAL: begin
                state_d = IDLE;
                if (v_ignore) begin
                    pop = 1'b1;
                end else if (v_err || (v_bypass && head.bypass_cnt == CNT_W'(MAX_BYPASS))) begin
                    pop      = 1'b1;
                    err_d    = 1'b1;
                    err_id_d = head.id;
                end else if (v_bypass) begin
                    pop    = 1'b1;
                    repush = 1'b1;
                end else if (v_present) begin
                    rsp_valid_d = 1'b1;
                    rsp_level_d = head.level;
                    rsp_id_d    = head.id;
                    rsp_sd_d    = head.is_local ? sd_local_i : head.sd;
                    rsp_local_d = head.is_local;
                    state_d     = RESP;
                end else begin
                    pop = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    pop         = 1'b1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A re-push lands at the tail; a simultaneous upstream push goes one slot behind it.
    always_comb begin
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        push_idx = repush ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        wr_ptr_d = push ? ptr_inc(push_idx) : push_idx;
        cnt_d    = cnt_q + OCC_W'(push) + OCC_W'(repush) - OCC_W'(pop);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_level_q <= '0;
            rsp_id_q    <= '0;
            rsp_sd_q    <= '0;
            rsp_local_q <= 1'b0;
            err_q       <= 1'b0;
            err_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_level_q <= rsp_level_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sd_q    <= rsp_sd_d;
            rsp_local_q <= rsp_local_d;
            err_q       <= err_d;
            err_id_q    <= err_id_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide which slots are valid.
    always_ff @(posedge clk_i) begin
        if (repush) mem_q[wr_ptr_q] <= repush_entry;
        if (push)   mem_q[push_idx] <= new_entry;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_level = rsp_level_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sd    = rsp_sd_q;
    assign bus.rsp_local = rsp_local_q;
    assign err_o         = err_q;
    assign err_id_o      = err_id_q;
endmodule

// File: tb/tb_fractal_sync_1d_rf_issue.sv
// Directed bench for fractal_sync_1d_rf_issue: a queue-level model predicts every output
// each cycle, and literal expectations pin latency, ordering and reset behaviour.
module tb_fractal_sync_1d_rf_issue;
    localparam int LW    = 1;
    localparam int IW    = 2;
    localparam int SW    = fractal_sync_pkg::SD_WIDTH;
    localparam int DEPTH = 4;
    localparam int MAXB  = 7;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    fractal_sync_1d_rf_issue_if #(.LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SW)) bus ();

    logic [LW-1:0] level_o;
    logic [IW-1:0] id_o, err_id_o;
    logic [SW-1:0] sd_local_o, sd_local_i;
    logic check_local_o, check_remote_o, err_o;
    logic present_local_i, present_remote_i, id_err_i, sig_err_i;
    logic bypass_local_i, bypass_remote_i, ignore_local_i, ignore_remote_i;

    fractal_sync_1d_rf_issue #(
        .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH), .MAX_BYPASS(MAXB)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_i), .bus(bus),
        .level_o(level_o), .id_o(id_o), .sd_local_o(sd_local_o),
        .check_local_o(check_local_o), .check_remote_o(check_remote_o),
        .present_local_i(present_local_i), .present_remote_i(present_remote_i),
        .id_err_i(id_err_i), .sig_err_i(sig_err_i),
        .bypass_local_i(bypass_local_i), .bypass_remote_i(bypass_remote_i),
        .ignore_local_i(ignore_local_i), .ignore_remote_i(ignore_remote_i),
        .sd_local_i(sd_local_i), .err_o(err_o), .err_id_o(err_id_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of pending requests ----------------
    typedef struct {
        int level;
        int id;
        int sd;
        bit is_local;
        int bypasses;
    } m_req_t;
    typedef enum {M_IDLE, M_CHECK, M_EVAL, M_RESP} m_phase_e;

    m_req_t   mq[$];
    m_phase_e ph = M_IDLE;
    bit m_rsp_valid = 0, m_rsp_local = 0, m_err = 0;
    int m_rsp_level = 0, m_rsp_id = 0, m_rsp_sd = 0, m_err_id = 0;
    int cyc = 0;

    task automatic model_step();
        m_req_t h, n;
        bit do_push, ign, er, byp, pres;
        if (rst_i) begin
            mq.delete();
            ph = M_IDLE;
            m_rsp_valid = 0; m_rsp_local = 0; m_rsp_level = 0; m_rsp_id = 0; m_rsp_sd = 0;
            m_err = 0; m_err_id = 0;
            return;
        end
        do_push = bus.req_valid && (mq.size() < DEPTH);
        n = '{level: int'(bus.req_level), id: int'(bus.req_id), sd: int'(bus.req_sd),
              is_local: bus.req_local, bypasses: 0};
        m_err = 0;
        m_err_id = 0;
        case (ph)
            M_IDLE:  if (mq.size() > 0) ph = M_CHECK;
            M_CHECK: ph = M_EVAL;
            M_EVAL: begin
                h    = mq[0];
                ign  = h.is_local ? ignore_local_i  : ignore_remote_i;
                er   = h.is_local ? id_err_i        : sig_err_i;
                byp  = h.is_local ? bypass_local_i  : bypass_remote_i;
                pres = h.is_local ? present_local_i : present_remote_i;
                ph = M_IDLE;
                if (ign) void'(mq.pop_front());
                else if (er || (byp && h.bypasses == MAXB)) begin
                    void'(mq.pop_front());
                    m_err = 1;
                    m_err_id = h.id;
                end else if (byp) begin
                    void'(mq.pop_front());
                    h.bypasses++;
                    mq.push_back(h);
                end else if (pres) begin
                    m_rsp_valid = 1;
                    m_rsp_level = h.level;
                    m_rsp_id    = h.id;
                    m_rsp_sd    = h.is_local ? int'(sd_local_i) : h.sd;
                    m_rsp_local = h.is_local;
                    ph = M_RESP;
                end else void'(mq.pop_front());
            end
            M_RESP: begin
                if (bus.rsp_ready) begin
                    void'(mq.pop_front());
                    m_rsp_valid = 0;
                    ph = M_IDLE;
                end
            end
            default: ph = M_IDLE;
        endcase
        if (do_push) mq.push_back(n);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cyc++;
    end

    // ---------------- per-cycle compare plus event observation ----------------
    int n_chk = 0, n_chk_remote = 0, n_err = 0, last_err_id = -1, n_rsp_cyc = 0;
    int chk_ids[$];
    int chk_cycs[$];

    task automatic clr_obs();
        n_chk = 0; n_chk_remote = 0; n_err = 0; last_err_id = -1; n_rsp_cyc = 0;
        chk_ids.delete();
        chk_cycs.delete();
    endtask

    task automatic compare_cycle();
        bit ne;
        ne = mq.size() > 0;
        check("req_ready", 32'(bus.req_ready), 32'(!rst_i && mq.size() < DEPTH));
        check("level_o", 32'(level_o), ne ? 32'(mq[0].level) : 32'd0);
        check("id_o", 32'(id_o), ne ? 32'(mq[0].id) : 32'd0);
        check("sd_local_o", 32'(sd_local_o), ne ? 32'(mq[0].sd) : 32'd0);
        check("check_local", 32'(check_local_o), 32'(ph == M_CHECK && ne && mq[0].is_local));
        check("check_remote", 32'(check_remote_o), 32'(ph == M_CHECK && ne && !mq[0].is_local));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
        check("err_o", 32'(err_o), 32'(m_err));
        check("err_id_o", 32'(err_id_o), 32'(m_err_id));
        if (m_rsp_valid) begin
            check("rsp_level", 32'(bus.rsp_level), 32'(m_rsp_level));
            check("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
            check("rsp_sd", 32'(bus.rsp_sd), 32'(m_rsp_sd));
            check("rsp_local", 32'(bus.rsp_local), 32'(m_rsp_local));
        end
        if (check_local_o || check_remote_o) begin
            n_chk++;
            if (check_remote_o) n_chk_remote++;
            chk_ids.push_back(int'(id_o));
            chk_cycs.push_back(cyc);
        end
        if (err_o) begin
            n_err++;
            last_err_id = int'(err_id_o);
        end
        if (bus.rsp_valid) n_rsp_cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) compare_cycle();
    end

    // ---------------- stimulus helpers (inputs change at posedge + 2) ----------------
    int push_cyc = 0;

    task automatic do_push(input int lvl, input int id, input int sd, input bit loc);
        bit ok;
        ok = 0;
        bus.req_valid = 1'b1;
        bus.req_level = LW'(lvl);
        bus.req_id    = IW'(id);
        bus.req_sd    = SW'(sd);
        bus.req_local = loc;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1;
                push_cyc = cyc;
            end
            @(posedge clk);
            #2;
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done;
        done = 0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            if (mq.size() == 0 && ph == M_IDLE && !m_rsp_valid) done = 1;
            @(posedge clk);
            #2;
        end
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    task automatic clear_verdict();
        present_local_i = 0; present_remote_i = 0; id_err_i = 0; sig_err_i = 0;
        bypass_local_i = 0; bypass_remote_i = 0; ignore_local_i = 0; ignore_remote_i = 0;
        sd_local_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int exp_ids[8];
        exp_ids = '{0, 1, 2, 0, 3, 1, 2, 0};
        bus.req_valid = 0; bus.req_level = '0; bus.req_id = '0; bus.req_sd = '0;
        bus.req_local = 0; bus.rsp_ready = 0;
        clear_verdict();

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        #2 rst_i = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;

        // 1: single local request, RF returns nothing
        clr_obs();
        do_push(0, 1, 1, 1'b1);
        wait_idle("t1_idle_timeout", 40);
        check("t1_checks", 32'(n_chk), 32'd1);
        check("t1_latency", 32'(chk_cycs.size() > 0 ? chk_cycs[0] - push_cyc : -1), 32'd2);
        check("t1_err", 32'(n_err), 32'd0);
        check("t1_rsp", 32'(n_rsp_cyc), 32'd0);

        // 2: local present, response held for 3 cycles without ready
        clr_obs();
        present_local_i = 1; sd_local_i = 2'b11;
        do_push(1, 1, 1, 1'b1);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        check("t2_rsp_rise", 32'(seen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t2_hold_id", 32'(bus.rsp_id), 32'd1);
            check("t2_hold_sd", 32'(bus.rsp_sd), 32'd3);
        end
        @(posedge clk);
        #2 bus.rsp_ready = 1;
        @(posedge clk);
        #2 bus.rsp_ready = 0;
        @(negedge clk);
        check("t2_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        check("t2_rsp_cycles", 32'(n_rsp_cyc), 32'd4);
        clear_verdict();
        wait_idle("t2_idle_timeout", 20);

        // 3: remote request bypassed every time until it errors
        clr_obs();
        bypass_remote_i = 1;
        do_push(0, 2, 2, 1'b0);
        wait_idle("t3_idle_timeout", 100);
        check("t3_checks", 32'(n_chk_remote), 32'd8);
        check("t3_err_count", 32'(n_err), 32'd1);
        check("t3_err_id", 32'(last_err_id), 32'd2);
        @(negedge clk);
        check("t3_empty", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;

        // 4: full FIFO with the head bypassed: rotation, ready stays low
        clr_obs();
        for (int i = 0; i < DEPTH; i++) do_push(i % 2, i, i, 1'b0);
        for (int k = 0; k < 40 && n_chk < 5; k++) @(negedge clk);
        check("t4_full_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #2;
        wait_idle("t4_idle_timeout", 250);
        for (int i = 0; i < 8; i++)
            check("t4_order", 32'(i < chk_ids.size() ? chk_ids[i] : -1), 32'(exp_ids[i]));
        check("t4_checks", 32'(n_chk), 32'd32);
        check("t4_errs", 32'(n_err), 32'd4);
        clear_verdict();

        // 5: ignore outranks id error
        clr_obs();
        ignore_local_i = 1; id_err_i = 1;
        do_push(1, 3, 2, 1'b1);
        wait_idle("t5_idle_timeout", 40);
        check("t5_checks", 32'(n_chk), 32'd1);
        check("t5_err", 32'(n_err), 32'd0);
        check("t5_rsp", 32'(n_rsp_cyc), 32'd0);
        clear_verdict();

        // 6: reset while responding with 3 entries queued
        clr_obs();
        present_local_i = 1; sd_local_i = 2'b10;
        do_push(0, 1, 1, 1'b1);
        do_push(1, 2, 2, 1'b1);
        do_push(0, 3, 3, 1'b1);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        check("t6_in_resp", 32'(seen), 32'd1);
        check("t6_queued", 32'(mq.size()), 32'd3);
        @(posedge clk);
        #2 rst_i = 1;
        @(negedge clk);
        check("t6_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #2 rst_i = 0;
        @(negedge clk);
        check("t6_rsp_flushed", 32'(bus.rsp_valid), 32'd0);
        check("t6_err_low", 32'(err_o), 32'd0);
        check("t6_ready", 32'(bus.req_ready), 32'd1);
        check("t6_head_zero", 32'(id_o), 32'd0);
        clear_verdict();
        @(posedge clk);
        #2;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
